// File: rtl/boot_seq_pkg.sv
// Shared definitions for the boot sequence controller.
//   state_e        : controller FSM states
//   FC_*           : fault_code encodings reported on fault
//   BOOT_SIGNATURE : value expected in boot ROM word 0
//   word_addr()    : converts an 8-bit word index to a ROM byte address (index on bits [9:2])
package boot_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    KICK,
    WAIT_HASH,
    RD_SIG,
    CHK_SIG,
    RD_WORD,
    CAP_WORD,
    WR_WORD,
    DONE,
    FAULT
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_BAD_SIG = 2'b10;

  localparam logic [31:0] BOOT_SIGNATURE = 32'hCAFE_BABE;

  function automatic logic [31:0] word_addr(input logic [7:0] idx);
    return {22'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_seq_timer.sv
// Hash-wait timeout counter for boot_seq_ctrl. Only compiled when the
// BOOT_SEQ_TIMEOUT_EN macro is defined; the default build has no counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : synchronous clear (asserted the cycle before the wait starts)
//   enable_i    : count one per cycle while waiting
//   expired_o   : high in the wait cycle that completes TIMEOUT_CYCLES cycles
`ifdef BOOT_SEQ_TIMEOUT_EN
module boot_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds at LIMIT so it can never wrap if the FSM lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so the last permitted cycle sees LIMIT.
  assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/boot_seq_ctrl.sv
// Boot sequence controller: kicks the boot ROM, waits for its hash check,
// verifies the signature in ROM word 0, copies COPY_WORDS firmware words to
// DEST_BASE over a valid/ready write port, then releases the CPU reset.
// Optional feature: define BOOT_SEQ_TIMEOUT_EN to fault (fault_code 01) when
// the hash wait lasts TIMEOUT_CYCLES cycles; otherwise the wait is unbounded.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : single-cycle boot request (honoured in IDLE only)
//   rom_cs/rom_read_en/rom_addr: one-cycle ROM read requests
//   rom_data                   : ROM read data, valid the cycle after a request
//   rom_hash_valid/boot_ready  : ROM status, both needed to leave the hash wait
//   cpy_valid/ready/addr/data  : firmware copy write channel
//   cpu_rst_n                  : 1 once boot succeeded
//   busy/done/fault/fault_code : sequence status (done/fault sticky until reset)
module boot_seq_ctrl
  import boot_seq_pkg::*;
#(
  parameter int          COPY_WORDS     = 16,
  parameter logic [31:0] DEST_BASE      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_cs,
  output logic        rom_read_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_hash_valid,
  input  logic        rom_boot_ready,
  output logic        cpy_valid,
  input  logic        cpy_ready,
  output logic [31:0] cpy_addr,
  output logic [31:0] cpy_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [7:0] LAST_IDX = 8'(COPY_WORDS);

  state_e      state_q;
  logic [7:0]  idx_q;
  logic        rom_cs_q, rom_rd_q;
  logic [31:0] rom_addr_q;
  logic        cpy_valid_q;
  logic [31:0] cpy_addr_q, cpy_data_q;
  logic        cpu_rst_n_q, busy_q, done_q, fault_q;
  logic [1:0]  fault_code_q;

`ifdef BOOT_SEQ_TIMEOUT_EN
  logic tmo_expired;

  // Cleared while in KICK so the count starts at zero on WAIT_HASH entry.
  boot_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == KICK),
    .enable_i (state_q == WAIT_HASH),
    .expired_o(tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Outputs are registered: each transition loads the values the next state drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      rom_cs_q     <= 1'b0;
      rom_rd_q     <= 1'b0;
      rom_addr_q   <= '0;
      cpy_valid_q  <= 1'b0;
      cpy_addr_q   <= '0;
      cpy_data_q   <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      // ROM requests last exactly one cycle unless a transition re-arms them.
      rom_cs_q   <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= KICK;
            rom_cs_q <= 1'b1;
            rom_rd_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        KICK: state_q <= WAIT_HASH;
        WAIT_HASH: begin
          if (rom_hash_valid && rom_boot_ready) begin
            state_q  <= RD_SIG;
            rom_cs_q <= 1'b1;
            rom_rd_q <= 1'b1;
          end
`ifdef BOOT_SEQ_TIMEOUT_EN
          else if (tmo_expired) begin
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
            busy_q       <= 1'b0;
          end
`endif
        end
        RD_SIG: state_q <= CHK_SIG;
        CHK_SIG: begin
          if (rom_data == BOOT_SIGNATURE) begin
            state_q    <= RD_WORD;
            idx_q      <= 8'd1;
            rom_cs_q   <= 1'b1;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= word_addr(8'd1);
          end else begin
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_BAD_SIG;
            busy_q       <= 1'b0;
          end
        end
        RD_WORD: state_q <= CAP_WORD;
        CAP_WORD: begin
          state_q     <= WR_WORD;
          cpy_data_q  <= rom_data;
          cpy_addr_q  <= DEST_BASE + word_addr(idx_q - 8'd1);
          cpy_valid_q <= 1'b1;
        end
        WR_WORD: begin
          if (cpy_ready) begin
            cpy_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q    <= RD_WORD;
              idx_q      <= idx_q + 8'd1;
              rom_cs_q   <= 1'b1;
              rom_rd_q   <= 1'b1;
              rom_addr_q <= word_addr(idx_q + 8'd1);
            end
          end
        end
        DONE:    state_q <= DONE;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_cs      = rom_cs_q;
  assign rom_read_en = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign cpy_valid   = cpy_valid_q;
  assign cpy_addr    = cpy_addr_q;
  assign cpy_data    = cpy_data_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Self-checking bench for boot_seq_ctrl with a registered ROM model, a
// write-channel scoreboard and randomized ROM contents, hash delays and
// cpy_ready back-pressure.
module tb_boot_seq_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TMO  = 100;

  logic        clk, rst_n, start;
  logic        rom_cs, rom_read_en;
  logic [31:0] rom_addr, rom_data;
  logic        rom_hash_valid, rom_boot_ready;
  logic        cpy_valid, cpy_ready;
  logic [31:0] cpy_addr, cpy_data;
  logic        cpu_rst_n, busy, done, fault;
  logic [1:0]  fault_code;

  boot_seq_ctrl #(
    .COPY_WORDS    (N),
    .DEST_BASE     (BASE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .rom_cs        (rom_cs),
    .rom_read_en   (rom_read_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_hash_valid(rom_hash_valid),
    .rom_boot_ready(rom_boot_ready),
    .cpy_valid     (cpy_valid),
    .cpy_ready     (cpy_ready),
    .cpy_addr      (cpy_addr),
    .cpy_data      (cpy_data),
    .cpu_rst_n     (cpu_rst_n),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered boot ROM model.
  logic [31:0] rom_mem [0:255];
  initial rom_data = '0;
  always @(posedge clk) if (rom_cs && rom_read_en) rom_data <= rom_mem[rom_addr[9:2]];

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int kicks = 0, writes = 0, kick_cyc = -1, fault_cyc = -1;
  int hash_delay = 0, hash_cnt = 0;
  bit hash_armed = 0, hash_never = 0;
  int ready_mode = 0, stall_left = 0, valid_len = 0;
  bit expect_done_next = 0, prev_cs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // cpy_ready driver: 0 always ready, 1 random, 2 stall word 2 five cycles, 3 refuse word 3.
  initial begin
    cpy_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: cpy_ready = ($urandom_range(0, 99) < 50);
        2: if (cpy_valid && cpy_addr == BASE + 32'd4 && stall_left > 0) begin
             cpy_ready = 1'b0;
             stall_left--;
           end else cpy_ready = 1'b1;
        3: cpy_ready = !(cpy_valid && cpy_addr == BASE + 32'd8);
        default: cpy_ready = 1'b1;
      endcase
    end
  end

  // Monitor: ROM request rules, hash stimulus, write scoreboard, done timing.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fault && fault_cyc < 0) fault_cyc = cyc;
        if (hash_armed) begin
          if (hash_cnt == 0) begin
            rom_hash_valid = 1'b1;
            rom_boot_ready = 1'b1;
            hash_armed = 0;
          end else hash_cnt--;
        end
        if (rom_cs) begin
          chk("rom_req_single_cycle", prev_cs, 0);
          chk("rom_read_en_with_cs", rom_read_en, 1);
          chk("rom_idle_while_writing", cpy_valid, 0);
          if (rom_addr == 32'd0 && !rom_hash_valid) begin
            kicks++;
            kick_cyc = cyc;
            hash_cnt = hash_delay;
            hash_armed = !hash_never;
          end
        end
        if (expect_done_next) begin
          chk("done_after_last_accept", {done, cpu_rst_n, busy}, 3'b110);
          expect_done_next = 0;
        end
        if (cpy_valid) begin
          valid_len++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: actual addr %0h data %0h required no write", cpy_addr, cpy_data);
          end else begin
            chk("cpy_addr", cpy_addr, exp_q[0].addr);
            chk("cpy_data", cpy_data, exp_q[0].data);
            chk("busy_while_copying", busy, 1);
            if (cpy_ready) begin
              e = exp_q.pop_front();
              writes++;
              if (ready_mode == 2 && e.addr == BASE + 32'd4) chk("stall_valid_cycles", valid_len, 6);
              if (exp_q.size() == 0) expect_done_next = 1;
            end
          end
          if (cpy_ready) valid_len = 0;
        end else valid_len = 0;
        prev_cs = rom_cs;
      end else prev_cs = 0;
    end
  end

  task automatic check_reset_outputs();
    chk("reset_outputs_zero",
        {rom_cs, rom_read_en, rom_addr, cpy_valid, cpy_addr, cpy_data,
         cpu_rst_n, busy, done, fault, fault_code}, 0);
  endtask

  task automatic do_reset(input bit start_after);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    rom_hash_valid = 1'b0;
    rom_boot_ready = 1'b0;
    hash_armed = 0;
    hash_never = 0;
    exp_q.delete();
    kicks = 0;
    writes = 0;
    kick_cyc = -1;
    fault_cyc = -1;
    expect_done_next = 0;
    #1 check_reset_outputs();
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    start = start_after;
    if (start_after) begin
      @(posedge clk);
      #2 start = 1'b0;
    end
  endtask

  task automatic load_rom(input logic [31:0] sig);
    rom_mem[0] = sig;
    for (int k = 1; k < 256; k++) rom_mem[k] = $urandom;
  endtask

  task automatic push_expected();
    for (int k = 1; k <= N; k++) exp_q.push_back('{addr: BASE + 32'(4 * (k - 1)), data: rom_mem[k]});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit ended = 0;
    for (int i = 0; i < budget && !ended; i++) begin
      @(negedge clk);
      if (done || fault) ended = 1;
    end
    chk("sequence_ends_within_budget", ended, 1);
  endtask

  task automatic run_good(input int mode, input int delay, input bit extra_starts);
    load_rom(32'hCAFE_BABE);
    push_expected();
    hash_delay = delay;
    ready_mode = mode;
    stall_left = 5;
    pulse_start();
    if (extra_starts) begin
      repeat (20) @(posedge clk);
      pulse_start();
      repeat (60) @(posedge clk);
      pulse_start();
    end
    wait_end(3000);
    @(negedge clk);
    chk("good_kicks", kicks, 1);
    chk("good_writes", writes, N);
    chk("good_queue_empty", exp_q.size(), 0);
    chk("good_status", {done, cpu_rst_n, fault, fault_code, busy}, 6'b110000);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    rom_hash_valid = 1'b0;
    rom_boot_ready = 1'b0;
    load_rom(32'hCAFE_BABE);

    // Nominal boot, hash after 70 cycles, extra starts while busy and after done.
    do_reset(0);
    run_good(0, 70, 1);
    pulse_start();
    repeat (100) @(negedge clk);
    chk("post_done_no_second_kick", kicks, 1);
    chk("post_done_no_extra_writes", writes, N);
    chk("post_done_status", {done, cpu_rst_n, fault, busy}, 4'b1100);

    // Back-pressure on word 2 for five cycles.
    do_reset(0);
    run_good(2, $urandom_range(1, 30), 0);

    // Random hash delays and random cpy_ready.
    for (int r = 0; r < 3; r++) begin
      do_reset(0);
      run_good(1, $urandom_range(1, 40), 0);
    end

    // Bad signature.
    do_reset(0);
    load_rom(32'hDEAD_BEEF);
    hash_delay = 10;
    ready_mode = 0;
    pulse_start();
    wait_end(500);
    @(negedge clk);
    chk("badsig_status", {done, cpu_rst_n, fault, fault_code, busy}, 6'b001100);
    repeat (20) @(negedge clk);
    chk("badsig_held", {fault, fault_code, cpu_rst_n}, 4'b1100);
    chk("badsig_no_writes", writes, 0);

    // Reset while word 3 is pending, then restart with start right after release.
    do_reset(0);
    load_rom(32'hCAFE_BABE);
    push_expected();
    hash_delay = 10;
    ready_mode = 3;
    pulse_start();
    begin
      bit seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (cpy_valid && cpy_addr == BASE + 32'd8) seen = 1;
      end
      chk("word3_pending_reached", seen, 1);
    end
    chk("writes_before_reset", writes, 2);
    ready_mode = 0;
    do_reset(1);
    push_expected();
    wait_end(1000);
    @(negedge clk);
    chk("restart_kicks", kicks, 1);
    chk("restart_writes", writes, N);
    chk("restart_status", {done, cpu_rst_n, fault, busy}, 4'b1100);

    // Hash never becomes valid.
    do_reset(0);
    hash_never = 1;
    load_rom(32'hCAFE_BABE);
    pulse_start();
`ifdef BOOT_SEQ_TIMEOUT_EN
    wait_end(TMO + 50);
    @(negedge clk);
    chk("timeout_status", {done, cpu_rst_n, fault, fault_code, busy}, 6'b001010);
    chk("timeout_latency", fault_cyc - kick_cyc, TMO + 1);
`else
    repeat (300) @(negedge clk);
    chk("no_timeout_waits", {busy, done, fault, fault_code, cpu_rst_n}, 6'b100000);
`endif
    do_reset(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/boot_seq_ctrl.md
BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

Interface
REQ-001 Parameter COPY_WORDS, default 16, SHALL set the number of firmware words copied after the header (range 1..255).
REQ-002 Parameter DEST_BASE, default 32'h8000_0000, SHALL set the byte address of the first copied word.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the hash-wait limit in clk cycles (used only with BOOT_SEQ_TIMEOUT_EN).
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle boot request.
- rom_cs  out  1  boot ROM chip select.
- rom_read_en  out  1  boot ROM read enable.
- rom_addr  out  32  ROM byte address; word index is bits [9:2].
- rom_data  in  32  ROM read data; registered, valid one cycle after a request.
- rom_hash_valid  in  1  ROM hash check passed.
- rom_boot_ready  in  1  ROM boot complete.
- cpy_valid  out  1  copy write valid.
- cpy_ready  in  1  copy write accept.
- cpy_addr  out  32  copy destination byte address.
- cpy_data  out  32  copy write data.
- cpu_rst_n  out  1  CPU reset release; 1 means released.
- busy  out  1  sequence in progress.
- done  out  1  boot succeeded; sticky.
- fault  out  1  boot failed; sticky.
- fault_code  out  2  01 timeout, 10 bad signature, 00 none.

Function
REQ-005 The FSM states SHALL be IDLE, KICK, WAIT_HASH, RD_SIG, CHK_SIG, RD_WORD, CAP_WORD, WR_WORD, DONE, FAULT.
REQ-006 IDLE->KICK SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-007 KICK SHALL drive rom_cs=1, rom_read_en=1, rom_addr=0 for exactly one cycle, then go to WAIT_HASH.
REQ-008 WAIT_HASH SHALL keep rom_cs=0 and SHALL go to RD_SIG in the cycle after rom_hash_valid=1 and rom_boot_ready=1 are sampled.
REQ-009 RD_SIG SHALL issue a one-cycle read of address 0; CHK_SIG SHALL then compare rom_data with 32'hCAFEBABE.
REQ-010 On a match, CHK_SIG SHALL go to RD_WORD with word index i=1; on a mismatch it SHALL go to FAULT with fault_code=10.
REQ-011 RD_WORD SHALL issue a one-cycle read at rom_addr=i<<2; CAP_WORD SHALL register rom_data into cpy_data.
REQ-012 WR_WORD SHALL drive cpy_valid=1 with cpy_addr=DEST_BASE+4*(i-1), holding cpy_addr and cpy_data stable until cpy_ready=1 is sampled.
REQ-013 On acceptance, if i==COPY_WORDS the FSM SHALL go to DONE; otherwise it SHALL increment i and go to RD_WORD.
REQ-014 cpy_valid=1 with cpy_ready=1 already high SHALL complete the transfer in one cycle; each word SHALL take at least 3 cycles.
REQ-015 DONE SHALL set done=1 and cpu_rst_n=1 in the cycle after the final acceptance; both SHALL stay set until reset.
REQ-016 FAULT SHALL set fault=1, keep cpu_rst_n=0, and hold fault_code until reset.
REQ-017 busy SHALL be 1 in every state except IDLE, DONE and FAULT.
REQ-018 Outside KICK, RD_SIG and RD_WORD, rom_cs, rom_read_en and rom_addr SHALL be 0; cpy_valid SHALL be 0 outside WR_WORD.
REQ-019 The index i SHALL be 8 bits wide and SHALL never exceed COPY_WORDS, so no wrap occurs.

Reset
REQ-020 rst_n=0 SHALL force every output to 0 at once, state to IDLE and i to 0, including mid-sequence (an in-flight cpy_valid is dropped).
REQ-021 start sampled in the first cycle after rst_n deasserts SHALL be honoured normally.

Configuration
REQ-022 With BOOT_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_HASH and increment each WAIT_HASH cycle.
REQ-023 With the macro defined, reaching TIMEOUT_CYCLES without the hash condition SHALL go to FAULT with fault_code=01.
REQ-024 Without the macro, WAIT_HASH SHALL wait indefinitely, no counter logic SHALL exist, and fault_code=01 SHALL never occur.

Structure
REQ-025 Package boot_seq_pkg SHALL hold the state enum, the fault-code constants, and BOOT_SIGNATURE=32'hCAFEBABE.
REQ-026 The timeout counter SHALL be a sub-module boot_seq_timer (clear, enable, expired), instantiated only under BOOT_SEQ_TIMEOUT_EN.

Verification
REQ-027 With a ROM model holding 0xCAFEBABE at word 0, hash_valid and boot_ready rising 70 cycles after KICK, COPY_WORDS=4, cpy_ready=1: pulse start -> 4 writes to 0x80000000..0x8000000C carrying words 1..4, then done=1, cpu_rst_n=1, fault=0.
REQ-028 With word 0 = 0xDEADBEEF: start -> no cpy_valid, fault=1, fault_code=10, cpu_rst_n=0.
REQ-029 With BOOT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100 and hash never valid: start -> fault=1 with fault_code=01 exactly 100 cycles after WAIT_HASH entry.
REQ-030 With cpy_ready low for 5 cycles on word 2: cpy_valid, cpy_addr=0x80000004 and cpy_data stay constant for 6 cycles, and the ROM is not read meanwhile.
REQ-031 With rst_n asserted during word 3 of 4 then released, followed by start: all outputs are 0 during reset, and the full sequence restarts at KICK and completes.
REQ-032 With start pulsed again while busy and again after done: the sequence is unchanged, no second KICK occurs, and done stays 1.
